// File: rtl/hazard_scoreboard_if.sv
// Hazard-unit signal bundle: per-stage register addresses and hazard inputs,
// plus the stall/flush/forward controls returned to the pipeline.
interface hazard_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic              RegWriteE, RegWriteM, RegWriteW;
    logic              MemtoRegE;
    logic              MultiD, MultiIssueE, MultiDone;
    logic [REG_AW-1:0] MultiRd;
    logic              PCSrcE;
    logic              MemReadyM;
    logic              StallF, StallD, StallE, StallM;
    logic              FlushD, FlushE, FlushW;
    logic [1:0]        ForwardAE, ForwardBE;
    logic [CNT_W-1:0]  StallCount;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteE, RegWriteM, RegWriteW, MemtoRegE,
        output MultiD, MultiIssueE, MultiDone, MultiRd, PCSrcE, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        input  ForwardAE, ForwardBE, StallCount
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE,
        input  MultiD, MultiIssueE, MultiDone, MultiRd, PCSrcE, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        output ForwardAE, ForwardBE, StallCount
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: operand forwarding, load-use bubbles, a multi-cycle
// op scoreboard, branch flushes and memory-wait freezes, with a stall counter.
module hazard_scoreboard #(
    parameter int REG_AW     = 5,
    parameter int LU_BUBBLES = 1,
    parameter int MAX_OUT    = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    hazard_scoreboard_if.slave hz
);
    localparam int NREG = 1 << REG_AW;
    localparam int OC_W = $clog2(MAX_OUT + 1);
    localparam logic [OC_W-1:0] OC_MAX  = OC_W'(MAX_OUT);
    localparam logic [1:0]      LU_INIT = (LU_BUBBLES > 1) ? 2'(LU_BUBBLES - 2) : 2'd0;

    typedef enum logic {IDLE, LU_STALL} state_t;

    state_t            state;
    logic [1:0]        lu_cnt;
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   set_vec, clr_vec;
    logic [OC_W-1:0]   out_cnt;
    logic [CNT_W-1:0]  stall_cnt;
    logic              lu_hit, sb_hit, issue, hz_stall;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic              wm,
        input logic [REG_AW-1:0] rdm,
        input logic              ww,
        input logic [REG_AW-1:0] rdw
    );
        if (wm && rdm != '0 && rdm == rs)
            return 2'b01;
        else if (ww && rdw != '0 && rdw == rs)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign lu_hit = hz.MemtoRegE && hz.RegWriteE && hz.RdE != '0 &&
                    (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
    assign sb_hit = pending[hz.Rs1D] || pending[hz.Rs2D] ||
                    (hz.MultiD && out_cnt == OC_MAX);
    // A memory wait freezes issue, so only completions touch the scoreboard then.
    assign issue    = hz.MemReadyM && hz.MultiIssueE;
    assign hz_stall = (state == LU_STALL) || lu_hit || sb_hit;

    always_comb begin
        hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
        hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
        hz.StallF = 1'b0;
        hz.StallD = 1'b0;
        hz.StallE = 1'b0;
        hz.StallM = 1'b0;
        hz.FlushD = 1'b0;
        hz.FlushE = 1'b0;
        hz.FlushW = 1'b0;
        if (!hz.MemReadyM) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.StallE = 1'b1;
            hz.StallM = 1'b1;
            hz.FlushW = 1'b1;
        end else if (hz.PCSrcE) begin
            hz.FlushD = 1'b1;
            hz.FlushE = 1'b1;
        end else if (hz_stall) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.FlushE = 1'b1;
        end
    end

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int i = 1; i < NREG; i++) begin
            set_vec[i] = issue && (hz.RdE == REG_AW'(i));
            clr_vec[i] = hz.MultiDone && (hz.MultiRd == REG_AW'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            lu_cnt <= 2'd0;
        end else if (!hz.MemReadyM) begin
            state <= state;
        end else if (hz.PCSrcE) begin
            state <= IDLE;
            lu_cnt <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (lu_hit && LU_BUBBLES > 1) begin
                        state <= LU_STALL;
                        lu_cnt <= LU_INIT;
                    end
                end
                LU_STALL: begin
                    if (lu_cnt == 2'd0)
                        state <= IDLE;
                    else
                        lu_cnt <= lu_cnt - 2'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Set is applied after clear so a same-cycle reissue of a register wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            out_cnt <= '0;
        end else begin
            pending <= (pending & ~clr_vec) | set_vec;
            if (issue && !hz.MultiDone) begin
                if (out_cnt != OC_MAX)
                    out_cnt <= out_cnt + 1'b1;
            end else if (hz.MultiDone && !issue) begin
                if (out_cnt != '0)
                    out_cnt <= out_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (hz.StallF && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign hz.StallCount = stall_cnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with three load-use bubbles and two
// outstanding multi-cycle ops; every expectation is hand-derived.
module tb_hazard_scoreboard;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    hazard_scoreboard_if #(.REG_AW(5), .CNT_W(16)) hz ();

    hazard_scoreboard #(
        .REG_AW(5), .LU_BUBBLES(3), .MAX_OUT(2), .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz(hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control bits packed as {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}.
    localparam logic [6:0] C_NONE   = 7'b0000000;
    localparam logic [6:0] C_STALL  = 7'b1100010;
    localparam logic [6:0] C_MEM    = 7'b1111001;
    localparam logic [6:0] C_BRANCH = 7'b0000110;

    function automatic logic [6:0] ctl();
        return {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushW};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0;
        hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
        hz.RegWriteE = 1'b0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
        hz.MemtoRegE = 1'b0; hz.MultiD = 1'b0; hz.MultiIssueE = 1'b0;
        hz.MultiDone = 1'b0; hz.MultiRd = '0; hz.PCSrcE = 1'b0;
        hz.MemReadyM = 1'b1;
    endtask

    task automatic drive_load(input logic [4:0] rd);
        hz.MemtoRegE = 1'b1; hz.RegWriteE = 1'b1; hz.RdE = rd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        checks++;
        if (ctl() !== C_NONE) begin
            errors++; $display("[TB] FAIL reset_ctl got %b want %b", ctl(), C_NONE);
        end
        checks++;
        if ({hz.ForwardAE, hz.ForwardBE} !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_fwd got %b want 0000", {hz.ForwardAE, hz.ForwardBE});
        end
        checks++;
        if (hz.StallCount !== 16'd0) begin
            errors++; $display("[TB] FAIL reset_cnt got %0d want 0", hz.StallCount);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_forwarding();
        logic [1:0] exp_a [5] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b10};
        logic [1:0] exp_b [5] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b01};
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            case (i)
                0: begin hz.RdM = 5; hz.RdW = 5; hz.RegWriteM = 1; hz.RegWriteW = 1; hz.Rs1E = 5; hz.Rs2E = 5; end
                1: begin hz.RdM = 5; hz.RdW = 5; hz.RegWriteW = 1; hz.Rs1E = 5; hz.Rs2E = 5; end
                2: begin hz.RdM = 0; hz.RegWriteM = 1; hz.Rs1E = 0; end
                3: begin hz.RdW = 0; hz.RegWriteW = 1; hz.Rs1E = 0; hz.Rs2E = 0; end
                default: begin hz.RdM = 3; hz.RegWriteM = 1; hz.RdW = 4; hz.RegWriteW = 1; hz.Rs1E = 4; hz.Rs2E = 3; end
            endcase
            #1;
            checks++;
            if (hz.ForwardAE !== exp_a[i]) begin
                errors++; $display("[TB] FAIL fwd_a[%0d] got %b want %b", i, hz.ForwardAE, exp_a[i]);
            end
            checks++;
            if (hz.ForwardBE !== exp_b[i]) begin
                errors++; $display("[TB] FAIL fwd_b[%0d] got %b want %b", i, hz.ForwardBE, exp_b[i]);
            end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_load_use();
        logic [6:0] exp;
        clear_inputs();
        drive_load(5'd0);
        hz.Rs1D = 0;
        #1;
        checks++;
        if (ctl() !== C_NONE) begin
            errors++; $display("[TB] FAIL lu_rd0 got %b want %b", ctl(), C_NONE);
        end
        drive_load(5'd7);
        hz.Rs2D = 7;
        for (int i = 0; i < 5; i++) begin
            #1;
            exp = (i < 3) ? C_STALL : C_NONE;
            checks++;
            if (ctl() !== exp) begin
                errors++; $display("[TB] FAIL lu_cycle[%0d] got %b want %b", i, ctl(), exp);
            end
            tick();
            clear_inputs();
        end
        checks++;
        if (hz.StallCount !== 16'd3) begin
            errors++; $display("[TB] FAIL lu_count got %0d want 3", hz.StallCount);
        end
    endtask

    task automatic test_scoreboard();
        clear_inputs();
        hz.MultiIssueE = 1; hz.RdE = 9;
        #1;
        checks++;
        if (ctl() !== C_NONE) begin
            errors++; $display("[TB] FAIL sb_issue got %b want %b", ctl(), C_NONE);
        end
        tick();
        clear_inputs();
        hz.Rs1D = 9;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin hz.MultiDone = 1; hz.MultiRd = 9; end
            #1;
            checks++;
            if (ctl() !== C_STALL) begin
                errors++; $display("[TB] FAIL sb_wait[%0d] got %b want %b", i, ctl(), C_STALL);
            end
            tick();
        end
        hz.MultiDone = 0;
        #1;
        checks++;
        if (ctl() !== C_NONE) begin
            errors++; $display("[TB] FAIL sb_release got %b want %b", ctl(), C_NONE);
        end
        clear_inputs();
        hz.MultiIssueE = 1; hz.RdE = 10;
        tick();
        hz.RdE = 11;
        tick();
        clear_inputs();
        hz.MultiD = 1;
        #1;
        checks++;
        if (ctl() !== C_STALL) begin
            errors++; $display("[TB] FAIL sb_full got %b want %b", ctl(), C_STALL);
        end
        hz.MultiDone = 1; hz.MultiRd = 10;
        tick();
        hz.MultiDone = 0;
        #1;
        checks++;
        if (ctl() !== C_NONE) begin
            errors++; $display("[TB] FAIL sb_not_full got %b want %b", ctl(), C_NONE);
        end
        hz.MultiD = 0;
        hz.MultiIssueE = 1; hz.RdE = 12; hz.MultiDone = 1; hz.MultiRd = 12;
        tick();
        clear_inputs();
        hz.Rs2D = 12;
        #1;
        checks++;
        if (ctl() !== C_STALL) begin
            errors++; $display("[TB] FAIL sb_set_wins got %b want %b", ctl(), C_STALL);
        end
        hz.MultiD = 1;
        #1;
        checks++;
        if (ctl() !== C_STALL) begin
            errors++; $display("[TB] FAIL sb_full_again got %b want %b", ctl(), C_STALL);
        end
        clear_inputs();
        hz.MultiDone = 1; hz.MultiRd = 12;
        tick();
        hz.MultiRd = 11;
        tick();
        clear_inputs();
        hz.Rs1D = 11; hz.Rs2D = 12; hz.MultiD = 1;
        #1;
        checks++;
        if (ctl() !== C_NONE) begin
            errors++; $display("[TB] FAIL sb_drained got %b want %b", ctl(), C_NONE);
        end
        clear_inputs();
    endtask

    task automatic test_branch_override();
        clear_inputs();
        drive_load(5'd7);
        hz.Rs1D = 7; hz.PCSrcE = 1;
        #1;
        checks++;
        if (ctl() !== C_BRANCH) begin
            errors++; $display("[TB] FAIL br_override got %b want %b", ctl(), C_BRANCH);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (ctl() !== C_NONE) begin
            errors++; $display("[TB] FAIL br_idle_next got %b want %b", ctl(), C_NONE);
        end
    endtask

    task automatic test_mem_stall();
        logic [6:0] exp;
        clear_inputs();
        drive_load(5'd7);
        hz.Rs1D = 7;
        tick();
        clear_inputs();
        hz.MemReadyM = 0; hz.PCSrcE = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (ctl() !== C_MEM) begin
                errors++; $display("[TB] FAIL mem_wait[%0d] got %b want %b", i, ctl(), C_MEM);
            end
            tick();
        end
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            #1;
            exp = (i < 2) ? C_STALL : C_NONE;
            checks++;
            if (ctl() !== exp) begin
                errors++; $display("[TB] FAIL mem_resume[%0d] got %b want %b", i, ctl(), exp);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_stall();
        clear_inputs();
        hz.MultiIssueE = 1; hz.RdE = 9;
        tick();
        clear_inputs();
        drive_load(5'd7);
        hz.Rs2D = 7;
        tick();
        clear_inputs();
        rst = 1'b1;
        #1;
        checks++;
        if (ctl() !== C_NONE) begin
            errors++; $display("[TB] FAIL rst_mid_ctl got %b want %b", ctl(), C_NONE);
        end
        checks++;
        if (hz.StallCount !== 16'd0) begin
            errors++; $display("[TB] FAIL rst_mid_cnt got %0d want 0", hz.StallCount);
        end
        tick();
        rst = 1'b0;
        tick();
        hz.Rs1D = 9;
        #1;
        checks++;
        if (ctl() !== C_NONE) begin
            errors++; $display("[TB] FAIL rst_pending got %b want %b", ctl(), C_NONE);
        end
        clear_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_forwarding();
        test_load_use();
        test_scoreboard();
        test_branch_override();
        test_mem_stall();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
